fetch_sequencer: RTL and testbench

- Controls instruction fetch: owns the architectural PC, issues word fetches to instruction memory over a request/grant/response handshake, and presents fetched instructions to decode over a valid/ready handshake.
- Sequences PC+4, branch/jump redirects and exception redirects.
- Keeps at most one fetch outstanding.
- Drops stale responses after a redirect.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/pc_next_sel.sv | 30 +++
 rtl/fetch_sequencer.sv | 135 +++++++++++++
 tb/tb_fetch_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction fetch path.
package mips_pkg;

    localparam int          INSTR_W            = 32;
    localparam logic [31:0] PC_INC             = 32'd4;
    localparam logic [31:0] DEF_RESET_VECTOR   = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR     = 32'h0000_0180;

    // Fetch FSM encoding. The enum is used for the debug view; the
    // localparams are the encodings the state register is compared with.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } state_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: exception vector, redirect target, sequential
// increment or hold. All results are word aligned.
module pc_next_sel
    import mips_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic [31:0] pc_i,
    input  logic        exc_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_target_i,
    input  logic        advance_i,
    output logic [31:0] pc_next_o,
    output logic        redirect_o
);

    // Priority mux: exception beats branch redirect beats sequential advance.
    always_comb begin
        pc_next_o  = pc_i;
        redirect_o = exc_i | redirect_i;
        if (exc_i) begin
            pc_next_o = align_word(EXC_VECTOR);
        end else if (redirect_i) begin
            pc_next_o = align_word(redirect_target_i);
        end else if (advance_i) begin
            pc_next_o = pc_i + PC_INC;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues one word fetch at a time
// to instruction memory and presents the result to decode.
//
// Handshakes:
//   imem: a request transfers on a cycle where imem_req && imem_gnt; the
//         single response arrives later as a one-cycle imem_rvalid pulse.
//   decode: an instruction transfers on a cycle where if_valid && if_ready;
//         while if_valid is high and if_ready is low, if_pc/if_instr hold.
//         A redirect in the same cycle kills the instruction instead.
module fetch_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_target,
    input  logic               exc_valid,
    output logic               if_valid,
    output logic [31:0]        if_pc,
    output logic [INSTR_W-1:0] if_instr,
    input  logic               if_ready,
    output state_e             dbg_state
);

    logic [1:0]         state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic               drop_q, drop_d;
    logic               boot_q, boot_d;
    logic [31:0]        if_pc_q, if_pc_d;
    logic [INSTR_W-1:0] if_instr_q, if_instr_d;

    logic               not_idle;
    logic               redir;
    logic               advance;

    // Redirects have no meaning before the first fetch, so IDLE masks them.
    assign not_idle = (state_q != ST_IDLE);
    assign advance  = (state_q == ST_OUT) && if_ready && !redir;

    pc_next_sel #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_pc_next_sel (
        .pc_i              (pc_q),
        .exc_i             (exc_valid & not_idle),
        .redirect_i        (redirect_valid & not_idle),
        .redirect_target_i (redirect_target),
        .advance_i         (advance),
        .pc_next_o         (pc_d),
        .redirect_o        (redir)
    );

    // Fetch FSM, stale-response drop flag and decode-side output registers.
    always_comb begin
        state_d    = state_q;
        drop_d     = drop_q;
        boot_d     = 1'b0;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        case (state_q)
            ST_IDLE: begin
                // boot_q keeps IDLE for the first cycle after reset release.
                if (!boot_q) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (imem_gnt) begin
                    state_d = ST_WAIT;
                    // Granted with the old address: its response is stale.
                    if (redir) begin
                        drop_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (drop_q || redir) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        if_pc_d    = pc_q;
                        if_instr_d = imem_rdata;
                        state_d    = ST_OUT;
                    end
                end else if (redir) begin
                    drop_d = 1'b1;
                end
            end
            ST_OUT: begin
                // A redirect kills the presented instruction even if accepted.
                if (redir || if_ready) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= align_word(RESET_VECTOR);
            drop_q     <= 1'b0;
            boot_q     <= 1'b1;
            if_pc_q    <= '0;
            if_instr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            boot_q     <= boot_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    assign imem_req  = (state_q == ST_REQ);
    assign imem_addr = pc_q;
    assign if_valid  = (state_q == ST_OUT);
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;
    assign dbg_state = state_e'(state_q);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a small instruction memory model.
module tb_fetch_sequencer;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        exc_valid = 1'b0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready = 1'b0;
    state_e      dbg_state;

    fetch_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .exc_valid       (exc_valid),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .if_ready        (if_ready),
        .dbg_state       (dbg_state)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_vec  = 0;
    int n_fail = 0;

    // Memory model state.
    bit          auto_gnt  = 1'b1;
    int          lat       = 0;
    bit          pend      = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          wait_cnt  = 0;
    bit          ovr_en    = 1'b0;
    logic [31:0] ovr_data  = 32'h0;
    bit          bad_seen  = 1'b0;

    typedef struct {
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;
    vec_t vecs[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: sample the handshake before the edge, then update the
    // memory model's inputs 1 time unit after the edge.
    task automatic step();
        logic        req_s, gnt_s, rv_s;
        logic [31:0] addr_s;
        req_s  = imem_req;
        gnt_s  = imem_gnt;
        rv_s   = imem_rvalid;
        addr_s = imem_addr;
        @(posedge clk);
        #1;
        if (rv_s) pend = 1'b0;
        if (req_s === 1'b1 && gnt_s === 1'b1) begin
            pend      = 1'b1;
            pend_addr = addr_s;
            wait_cnt  = lat;
        end
        imem_gnt    = auto_gnt && (imem_req === 1'b1);
        imem_rvalid = 1'b0;
        if (pend) begin
            if (wait_cnt == 0) begin
                imem_rvalid = 1'b1;
                if (ovr_en) begin
                    imem_rdata = ovr_data;
                    ovr_en     = 1'b0;
                end else begin
                    imem_rdata = pend_addr ^ 32'hA5A5_A5A5;
                end
            end else begin
                wait_cnt--;
            end
        end
        if (if_valid === 1'b1 && if_instr === 32'hDEAD_BEEF) bad_seen = 1'b1;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (imem_req !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk(name, {31'h0, imem_req}, 32'h1);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (if_valid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk(name, {31'h0, if_valid}, 32'h1);
    endtask

    initial begin
        vecs[0] = '{32'h0000_0000, 32'h0000_0000, 32'hA5A5_A5A5};
        vecs[1] = '{32'h0000_0004, 32'h0000_0004, 32'hA5A5_A5A1};
        vecs[2] = '{32'h0000_0008, 32'h0000_0008, 32'hA5A5_A5AD};

        // Reset state.
        repeat (3) step();
        chk("rst_req",    {31'h0, imem_req}, 32'h0);
        chk("rst_valid",  {31'h0, if_valid}, 32'h0);
        chk("rst_if_pc",  if_pc, 32'h0);
        chk("rst_instr",  if_instr, 32'h0);
        chk("rst_addr",   imem_addr, 32'h0);

        // Release: request rises two cycles later.
        rst = 1'b1;
        step();
        chk("boot_req_c1", {31'h0, imem_req}, 32'h0);
        step();
        chk("boot_req_c2", {31'h0, imem_req}, 32'h1);

        // Zero-wait memory, decode always ready.
        if_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_req("seq_req");
            chk("seq_addr", imem_addr, vecs[i].exp_addr);
            wait_valid("seq_valid");
            chk("seq_pc", if_pc, vecs[i].exp_pc);
            chk("seq_instr", if_instr, vecs[i].exp_instr);
            step();
        end

        // Decode backpressure for 5 cycles.
        if_ready = 1'b0;
        wait_req("bp_req");
        chk("bp_addr", imem_addr, 32'h0000_000C);
        wait_valid("bp_valid0");
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", {31'h0, if_valid}, 32'h1);
            chk("bp_pc", if_pc, 32'h0000_000C);
            chk("bp_instr", if_instr, 32'hA5A5_A5A9);
            chk("bp_req_low", {31'h0, imem_req}, 32'h0);
        end
        if_ready = 1'b1;
        step();
        chk("bp_acc_valid", {31'h0, if_valid}, 32'h0);
        chk("bp_acc_req", {31'h0, imem_req}, 32'h1);
        chk("bp_acc_addr", imem_addr, 32'h0000_0010);

        // Redirect while waiting; stale response must be dropped.
        lat      = 2;
        ovr_en   = 1'b1;
        ovr_data = 32'hDEAD_BEEF;
        step();
        chk("wr_in_wait", {31'h0, imem_req}, 32'h0);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_1003;
        step();
        redirect_valid = 1'b0;
        lat = 0;
        wait_req("wr_req");
        chk("wr_addr", imem_addr, 32'h0000_1000);
        chk("wr_no_valid", {31'h0, if_valid}, 32'h0);
        if_ready = 1'b0;
        wait_valid("wr_valid");
        chk("wr_pc", if_pc, 32'h0000_1000);
        chk("wr_instr", if_instr, 32'hA5A5_B5A5);

        // Exception and redirect together in OUT while decode accepts.
        if_ready        = 1'b1;
        exc_valid       = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_2000;
        step();
        exc_valid      = 1'b0;
        redirect_valid = 1'b0;
        chk("exc_valid_fall", {31'h0, if_valid}, 32'h0);
        chk("exc_req", {31'h0, imem_req}, 32'h1);
        chk("exc_addr", imem_addr, 32'h0000_0180);
        wait_valid("exc_fetch_valid");
        chk("exc_pc", if_pc, 32'h0000_0180);
        chk("exc_instr", if_instr, 32'hA5A5_A425);
        step();

        // Redirect in ungranted REQ to the top word, then wrap on accept.
        auto_gnt = 1'b0;
        imem_gnt = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        chk("wrap_req", {31'h0, imem_req}, 32'h1);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        auto_gnt = 1'b1;
        imem_gnt = 1'b1;
        wait_valid("wrap_valid");
        chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_instr", if_instr, 32'h5A5A_5A59);
        step();
        wait_req("wrap_next_req");
        chk("wrap_next_addr", imem_addr, 32'h0000_0000);

        // Reset while in WAIT; the late response must be ignored.
        lat      = 3;
        ovr_en   = 1'b1;
        ovr_data = 32'hDEAD_BEEF;
        step();
        chk("mr_in_wait", {31'h0, imem_req}, 32'h0);
        rst = 1'b0;
        step();
        chk("mr_req", {31'h0, imem_req}, 32'h0);
        chk("mr_valid", {31'h0, if_valid}, 32'h0);
        chk("mr_if_pc", if_pc, 32'h0);
        chk("mr_instr", if_instr, 32'h0);
        chk("mr_addr", imem_addr, 32'h0);
        step();
        rst = 1'b1;
        step();
        chk("mr_boot_c1", {31'h0, imem_req}, 32'h0);
        step();
        chk("mr_boot_c2", {31'h0, imem_req}, 32'h1);
        chk("mr_boot_addr", imem_addr, 32'h0000_0000);
        lat = 0;
        wait_valid("mr_valid_after");
        chk("mr_pc_after", if_pc, 32'h0000_0000);
        chk("mr_instr_after", if_instr, 32'hA5A5_A5A5);
        chk("stale_never_presented", {31'h0, bad_seen}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
